// File: rtl/load_store_unit.sv
// Load/store sequencer between the execute stage and a registered-read data memory.
// Optional block copy is compiled in when LSU_COPY_EN is defined.
module load_store_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [7:0]        req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWriteData,
  input  logic [DATA_W-1:0] MemReadData,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
`ifdef LSU_COPY_EN
    , CRD  = 3'd5,
    CCAP = 3'd6,
    CWR  = 3'd7
`endif
  } state_t;

  state_t            state_r, state_s;
  logic              mem_we_r, mem_we_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_s;
  logic              rsp_err_r, rsp_err_s;
  logic              busy_r;

`ifdef LSU_COPY_EN
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  logic [ADDR_W-1:0] src_r, src_s;
  logic [ADDR_W-1:0] dst_r, dst_s;
  logic [7:0]        len_r, len_s;
  logic [7:0]        cnt_r, cnt_s;
  logic [7:0]        cnt_inc_s;
`else
  logic              unused_len_s;
  assign unused_len_s = ^req_len;
`endif

  // Next-state and next registered-output values
  always_comb begin
    state_s     = state_r;
    mem_we_s    = 1'b0;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    rsp_rdata_s = rsp_rdata_r;
    rsp_err_s   = rsp_err_r;
`ifdef LSU_COPY_EN
    src_s     = src_r;
    dst_s     = dst_r;
    len_s     = len_r;
    cnt_s     = cnt_r;
    cnt_inc_s = cnt_r + 8'd1;
`endif
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          case (req_op)
            2'b00: begin
              state_s    = RD;
              mem_addr_s = req_addr;
            end
            2'b01: begin
              state_s     = WR;
              mem_we_s    = 1'b1;
              mem_addr_s  = req_addr;
              mem_wdata_s = req_wdata;
              rsp_rdata_s = req_wdata;
              rsp_err_s   = 1'b0;
            end
`ifdef LSU_COPY_EN
            2'b10: begin
              src_s = req_addr;
              dst_s = ADDR_W'(req_wdata);
              len_s = req_len;
              cnt_s = 8'd0;
              if (req_len == 8'd0) begin
                state_s     = RESP;
                rsp_rdata_s = {DATA_W{1'b0}};
                rsp_err_s   = 1'b0;
              end else begin
                state_s    = CRD;
                mem_addr_s = req_addr;
              end
            end
`endif
            default: begin
              state_s     = RESP;
              rsp_rdata_s = {DATA_W{1'b0}};
              rsp_err_s   = 1'b1;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      RD:  state_s = CAP;
      CAP: begin
        state_s     = RESP;
        rsp_rdata_s = MemReadData;
        rsp_err_s   = 1'b0;
      end
      WR:  state_s = RESP;
`ifdef LSU_COPY_EN
      CRD: state_s = CCAP;
      CCAP: begin
        state_s     = CWR;
        mem_we_s    = 1'b1;
        mem_addr_s  = dst_r;
        mem_wdata_s = MemReadData;
      end
      CWR: begin
        // Both pointers wrap naturally at the address width
        src_s = src_r + ADDR_ONE;
        dst_s = dst_r + ADDR_ONE;
        cnt_s = cnt_inc_s;
        if (cnt_inc_s == len_r) begin
          state_s     = RESP;
          rsp_rdata_s = DATA_W'(len_r);
          rsp_err_s   = 1'b0;
        end else begin
          state_s    = CRD;
          mem_addr_s = src_r + ADDR_ONE;
        end
      end
`endif
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any operation and drops MemWrite at once
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= IDLE;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      rsp_valid_r <= (state_s == RESP);
      rsp_rdata_r <= rsp_rdata_s;
      rsp_err_r   <= rsp_err_s;
      busy_r      <= (state_s != IDLE);
    end
  end

`ifdef LSU_COPY_EN
  // Copy pointers and byte counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      src_r <= {ADDR_W{1'b0}};
      dst_r <= {ADDR_W{1'b0}};
      len_r <= 8'd0;
      cnt_r <= 8'd0;
    end else begin
      src_r <= src_s;
      dst_r <= dst_s;
      len_r <= len_s;
      cnt_r <= cnt_s;
    end
  end
`endif

  assign req_ready    = (state_r == IDLE) && !RST;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_rdata    = rsp_rdata_r;
  assign rsp_err      = rsp_err_r;
  assign MemWrite     = mem_we_r;
  assign MemAddr      = mem_addr_r;
  assign MemWriteData = mem_wdata_r;
  assign busy         = busy_r;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access initiator for the 8-bit single-cycle datapath: accepts load, store and optional block-copy requests from the core over a valid/ready handshake. It sequences them onto the data-memory port, which has a synchronous write, a registered read and a `MemWrite` strobe. Read data is captured internally and returned on a response channel with its own valid/ready handshake. The block sits between the core's execute stage and the data memory, replacing direct `MemWrite`/`ALUResult` drive.

## Interface
- `ADDR_W`, 8, memory address width; all address arithmetic is modulo 2^ADDR_W.
- `DATA_W`, 8, data width.
- `CLK`  in  1  clock, all state on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept; equals (state==IDLE) and !RST.
- `req_op`  in  2  00 load, 01 store, 10 copy, 11 reserved.
- `req_addr`  in  ADDR_W  load/store address; copy source.
- `req_wdata`  in  DATA_W  store data; copy destination address.
- `req_len`  in  8  copy byte count; ignored for other ops.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_rdata`  out  DATA_W  load: read byte; store: written byte; copy: bytes copied.
- `rsp_err`  out  1  reserved/unsupported op.
- `MemWrite`  out  1  write strobe to data memory.
- `MemAddr`  out  ADDR_W  memory address.
- `MemWriteData`  out  DATA_W  memory write data.
- `MemReadData`  in  DATA_W  memory registered read data, valid the cycle after its address is presented with `MemWrite`=0.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, RD, CAP, WR, CRD, CCAP, CWR, RESP.
- Handshake: transfer on a rising edge with `req_valid`&&`req_ready`; request fields are registered at that edge. `req_valid` outside IDLE is ignored.
- Load: IDLE→RD (MemAddr=addr, MemWrite=0)→CAP (register MemReadData)→RESP.
- Store: IDLE→WR (MemWrite=1 for exactly one cycle, MemAddr=addr, MemWriteData=wdata)→RESP; rsp_rdata=wdata.
- Copy, len L>0: per byte CRD (MemAddr=src)→CCAP (capture)→CWR (MemAddr=dst, write captured byte). Then src+1, dst+1 (both wrap 0xFF→0x00), count+1. Loops to CRD until count==L, then RESP with rsp_rdata=L.
- Copy L=0: IDLE→RESP, rsp_rdata=0, no memory access.
- Overlapping copy regions: strictly forward byte order; no overlap protection.
- Op 11: IDLE→RESP, rsp_err=1, rsp_rdata=0, no memory access.
- RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable until a rising edge with `rsp_ready`=1, then →IDLE.
- MemWrite is 0 in every state except WR and CWR; MemAddr and MemWriteData hold their last values in IDLE and RESP.

## Timing
- Cycle 0 = request accept edge. Load: rsp_valid from cycle 3. Store: write in cycle 1, rsp_valid from cycle 2. Copy L: 3L memory cycles, rsp_valid from cycle 3L+1.
- With `rsp_ready` held high, the next request can be accepted one cycle after the response transfer (IDLE cycle required).
- Reset values: state IDLE; MemWrite 0, MemAddr 0, MemWriteData 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0, req_ready 0 while RST is high.
- RST mid-operation: abort immediately; MemWrite drops asynchronously. Bytes already written remain, no further writes occur, and no response is issued.

## Configuration
- `LSU_COPY_EN` defined: copy op and states CRD/CCAP/CWR are compiled in.
- `LSU_COPY_EN` undefined: copy states are absent; op 10 is handled as reserved (rsp_err=1, no memory access).

## Test plan
- Memory preset Memory[i]=i. After reset, load 0x0A → rsp_valid at cycle 3, rsp_rdata 0x0A, rsp_err 0.
- Store 0x55 to 0x0A → MemWrite high exactly cycle 1 with MemAddr 0x0A, MemWriteData 0x55. A following load of 0x0A returns 0x55.
- Load 0x20 with rsp_ready low 5 cycles → rsp_valid, rsp_rdata 0x20 held, req_ready 0; a concurrent req_valid is not accepted.
- Copy src 0x10, dst 0x20, len 4 → Memory[0x20..0x23]=0x10..0x13, rsp_valid at cycle 13, rsp_rdata 4. Copy src 0xFE, dst 0x40, len 3 → reads 0xFE, 0xFF, 0x00.
- Op 11 → rsp_err 1, no MemWrite pulse. With `LSU_COPY_EN` undefined, op 10 → rsp_err 1.
- Copy src 0x10, dst 0x80, len 8; assert RST during the 3rd CRD → MemWrite 0 at once, only 0x80–0x81 modified, no rsp_valid, req_ready 1 after release.
